bus_drive_sequencer: RTL and testbench



---
 rtl/bus_drive_sequencer_if.sv | 26 ++
 rtl/bus_drive_sequencer.sv | 138 +++++++++++++
 tb/tb_bus_drive_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_drive_sequencer_if.sv
// rtl/bus_drive_sequencer_if.sv - request/bus/enable signal bundle for bus_drive_sequencer
interface bus_drive_sequencer_if #(
    parameter int NSRC  = 4,
    parameter int WIDTH = 8
);
    logic [NSRC-1:0]  REQ;
    logic [WIDTH-1:0] BUS_IN;
    logic [NSRC-1:0]  OENB_N;
    logic [WIDTH-1:0] DATA_OUT;
    logic             VALID;
    logic [2:0]       SRC;
    logic [NSRC-1:0]  ACK;
    logic             BUSY;

    // Requesters and the bus model sit on the master side.
    modport master (
        output REQ, BUS_IN,
        input  OENB_N, DATA_OUT, VALID, SRC, ACK, BUSY
    );

    // The sequencer itself.
    modport slave (
        input  REQ, BUS_IN,
        output OENB_N, DATA_OUT, VALID, SRC, ACK, BUSY
    );
endinterface

// File: rtl/bus_drive_sequencer.sv
// rtl/bus_drive_sequencer.sv - break-before-make round-robin enable sequencer for shared tristate bus
module bus_drive_sequencer #(
    parameter int NSRC  = 4,
    parameter int WIDTH = 8,
    parameter int HOLD  = 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    bus_drive_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [NSRC-1:0]  oenb_n_q, oenb_n_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [2:0]       src_q, src_d;
    logic [NSRC-1:0]  ack_q, ack_d;
    logic             busy_q, busy_d;

    logic             found, found_hi, found_lo;
    logic [2:0]       k, k_hi, k_lo;
    logic [NSRC-1:0]  grant_oenb_n;
    logic [NSRC-1:0]  ack_onehot;

    // Round-robin pick: lowest requester above the pointer, else lowest at/below it (wrap).
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        k_hi     = 3'd0;
        k_lo     = 3'd0;
        for (int j = NSRC - 1; j >= 0; j--) begin
            if (bus.REQ[j]) begin
                if (3'(j) > ptr_q) begin
                    found_hi = 1'b1;
                    k_hi     = 3'(j);
                end else begin
                    found_lo = 1'b1;
                    k_lo     = 3'(j);
                end
            end
        end
        found = found_hi | found_lo;
        k     = found_hi ? k_hi : k_lo;
    end

    // Decode the enable pattern for a new grant and the ack for the driver being retired.
    always_comb begin
        grant_oenb_n = '1;
        ack_onehot   = '0;
        for (int j = 0; j < NSRC; j++) begin
            grant_oenb_n[j] = (3'(j) != k);
            ack_onehot[j]   = (3'(j) == ptr_q);
        end
    end

    // Next-state and registered-output logic; VALID/ACK default low so they only pulse.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        oenb_n_d = oenb_n_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        src_d    = src_q;
        ack_d    = '0;
        case (state_q)
            IDLE, TURN: begin
                // Bus is guaranteed undriven here, so a new grant cannot overlap a previous one.
                oenb_n_d = '1;
                state_d  = IDLE;
                if (found) begin
                    ptr_d    = k;
                    cnt_d    = 4'(HOLD - 1);
                    oenb_n_d = grant_oenb_n;
                    state_d  = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    data_d   = bus.BUS_IN;
                    src_d    = ptr_q;
                    ack_d    = ack_onehot;
                    valid_d  = 1'b1;
                    oenb_n_d = '1;
                    state_d  = TURN;
                end
            end
            default: begin
                oenb_n_d = '1;
                state_d  = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; async reset releases the bus without waiting for a clock.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            ptr_q    <= 3'(NSRC - 1);
            cnt_q    <= 4'd0;
            oenb_n_q <= '1;
            data_q   <= '0;
            valid_q  <= 1'b0;
            src_q    <= 3'd0;
            ack_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            oenb_n_q <= oenb_n_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            src_q    <= src_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.OENB_N   = oenb_n_q;
    assign bus.DATA_OUT = data_q;
    assign bus.VALID    = valid_q;
    assign bus.SRC      = src_q;
    assign bus.ACK      = ack_q;
    assign bus.BUSY     = busy_q;

endmodule

// File: tb/tb_bus_drive_sequencer.sv
// tb/tb_bus_drive_sequencer.sv - scoreboard bench for bus_drive_sequencer at HOLD 1, 2 and 3
module tb_bus_drive_sequencer;

    logic clk;
    logic rst;

    bus_drive_sequencer_if #(.NSRC(4), .WIDTH(8)) if1 ();
    bus_drive_sequencer_if #(.NSRC(4), .WIDTH(8)) if2 ();
    bus_drive_sequencer_if #(.NSRC(4), .WIDTH(8)) if3 ();

    bus_drive_sequencer #(.NSRC(4), .WIDTH(8), .HOLD(1)) u_h1 (.CLK(clk), .RESET(rst), .bus(if1.slave));
    bus_drive_sequencer #(.NSRC(4), .WIDTH(8), .HOLD(2)) u_h2 (.CLK(clk), .RESET(rst), .bus(if2.slave));
    bus_drive_sequencer #(.NSRC(4), .WIDTH(8), .HOLD(3)) u_h3 (.CLK(clk), .RESET(rst), .bus(if3.slave));

    typedef struct {
        logic [2:0] src;
        logic [7:0] data;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];

    logic [7:0] val1 [4];
    logic [7:0] val2 [4];
    logic [7:0] val3 [4];
    logic [7:0] bus1, bus2, bus3;
    logic [3:0] prev_oe [3];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus model: the enabled driver's value, pulled to zero when nobody drives.
    always_comb begin
        bus1 = 8'h00;
        bus2 = 8'h00;
        bus3 = 8'h00;
        for (int j = 0; j < 4; j++) begin
            if (!if1.OENB_N[j]) bus1 = val1[j];
            if (!if2.OENB_N[j]) bus2 = val2[j];
            if (!if3.OENB_N[j]) bus3 = val3[j];
        end
    end
    assign if1.BUS_IN = bus1;
    assign if2.BUS_IN = bus2;
    assign if3.BUS_IN = bus3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic mon(input int id, input logic [2:0] src, input logic [7:0] data, input logic [3:0] ack);
        exp_t e;
        logic got;
        got = 1'b0;
        e.src = 3'd0;
        e.data = 8'h00;
        case (id)
            1: if (q1.size() != 0) begin e = q1.pop_front(); got = 1'b1; end
            2: if (q2.size() != 0) begin e = q2.pop_front(); got = 1'b1; end
            default: if (q3.size() != 0) begin e = q3.pop_front(); got = 1'b1; end
        endcase
        if (!got) begin
            chk($sformatf("unexpected_valid_h%0d", id), 32'd1, 32'd0);
        end else begin
            chk($sformatf("sb_src_h%0d", id), 32'(src), 32'(e.src));
            chk($sformatf("sb_data_h%0d", id), 32'(data), 32'(e.data));
            chk($sformatf("sb_ack_h%0d", id), 32'(ack), 32'(4'b0001 << e.src));
        end
    endtask

    task automatic inv(input int id, input logic [3:0] oe);
        chk($sformatf("one_low_max_h%0d", id), 32'($countones(~oe) <= 1), 32'd1);
        if (prev_oe[id-1] != 4'b1111 && oe != 4'b1111 && prev_oe[id-1] != oe)
            chk($sformatf("dead_cycle_h%0d", id), {28'd0, oe}, 32'hF);
        prev_oe[id-1] = oe;
    endtask

    // Monitor: pops the scoreboard on every VALID and watches the enable invariants.
    always @(negedge clk) begin
        if (!rst) begin
            if (if1.VALID) mon(1, if1.SRC, if1.DATA_OUT, if1.ACK);
            if (if2.VALID) mon(2, if2.SRC, if2.DATA_OUT, if2.ACK);
            if (if3.VALID) mon(3, if3.SRC, if3.DATA_OUT, if3.ACK);
            inv(1, if1.OENB_N);
            inv(2, if2.OENB_N);
            inv(3, if3.OENB_N);
        end
    end

    task automatic push(input int id, input logic [2:0] s, input logic [7:0] d);
        exp_t e;
        e.src = s;
        e.data = d;
        case (id)
            1: q1.push_back(e);
            2: q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    initial begin
        int nv;
        int cyc;
        int last;
        int seen;

        for (int i = 0; i < 3; i++) prev_oe[i] = 4'b1111;
        val1[0] = 8'hA0; val1[1] = 8'hB1; val1[2] = 8'hC2; val1[3] = 8'hD3;
        for (int i = 0; i < 4; i++) begin
            val2[i] = 8'h00;
            val3[i] = 8'h00;
        end
        rst = 1'b1;
        if1.REQ = 4'b1111;
        if2.REQ = 4'b0000;
        if3.REQ = 4'b0000;

        // Reset state with all requests raised.
        @(negedge clk);
        chk("rst_oenb", 32'(if1.OENB_N), 32'hF);
        chk("rst_valid", 32'(if1.VALID), 32'd0);
        chk("rst_data", 32'(if1.DATA_OUT), 32'h00);
        chk("rst_busy", 32'(if1.BUSY), 32'd0);
        chk("rst_src", 32'(if1.SRC), 32'd0);
        chk("rst_ack", 32'(if1.ACK), 32'd0);
        rst = 1'b0;
        push(1, 3'd0, 8'hA0);
        push(1, 3'd1, 8'hB1);
        push(1, 3'd2, 8'hC2);
        push(1, 3'd3, 8'hD3);
        push(1, 3'd0, 8'hA0);

        @(negedge clk);
        chk("first_grant_src0", 32'(if1.OENB_N), 32'hE);

        // All requesters held: 0,1,2,3,0 with a period of two cycles.
        nv = 0;
        cyc = 0;
        last = -1;
        while (nv < 5 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (if1.VALID) begin
                if (last >= 0) chk("rr_period", 32'(cyc - last), 32'd2);
                last = cyc;
                nv++;
            end
        end
        chk("rr_valid_count", 32'(nv), 32'd5);
        if1.REQ = 4'b0000;
        @(negedge clk);
        chk("rr_idle_busy", 32'(if1.BUSY), 32'd0);

        // Single request, HOLD=1.
        val1[2] = 8'hA5;
        if1.REQ = 4'b0100;
        push(1, 3'd2, 8'hA5);
        @(negedge clk);
        chk("h1_oenb_drive", 32'(if1.OENB_N), 32'hB);
        chk("h1_valid_drive", 32'(if1.VALID), 32'd0);
        if1.REQ = 4'b0000;
        @(negedge clk);
        chk("h1_valid", 32'(if1.VALID), 32'd1);
        chk("h1_data", 32'(if1.DATA_OUT), 32'hA5);
        chk("h1_src", 32'(if1.SRC), 32'd2);
        chk("h1_ack", 32'(if1.ACK), 32'h4);
        chk("h1_oenb_turn", 32'(if1.OENB_N), 32'hF);
        @(negedge clk);
        chk("h1_valid_drop", 32'(if1.VALID), 32'd0);
        chk("h1_busy_idle", 32'(if1.BUSY), 32'd0);

        // HOLD=3: bus value changes during drive, only the last one is kept.
        if3.REQ = 4'b0010;
        push(3, 3'd1, 8'h33);
        @(negedge clk);
        chk("h3_oenb_c1", 32'(if3.OENB_N), 32'hD);
        val3[1] = 8'h11;
        if3.REQ = 4'b0000;
        @(negedge clk);
        chk("h3_oenb_c2", 32'(if3.OENB_N), 32'hD);
        chk("h3_valid_c2", 32'(if3.VALID), 32'd0);
        val3[1] = 8'h22;
        @(negedge clk);
        chk("h3_oenb_c3", 32'(if3.OENB_N), 32'hD);
        chk("h3_valid_c3", 32'(if3.VALID), 32'd0);
        val3[1] = 8'h33;
        @(negedge clk);
        chk("h3_valid", 32'(if3.VALID), 32'd1);
        chk("h3_data", 32'(if3.DATA_OUT), 32'h33);
        chk("h3_oenb_rel", 32'(if3.OENB_N), 32'hF);
        @(negedge clk);
        chk("h3_single_pulse", 32'(if3.VALID), 32'd0);
        chk("h3_busy_idle", 32'(if3.BUSY), 32'd0);

        // HOLD=2: request dropped right after the grant still completes.
        val2[0] = 8'h5A;
        if2.REQ = 4'b0001;
        push(2, 3'd0, 8'h5A);
        @(negedge clk);
        chk("h2_oenb_c1", 32'(if2.OENB_N), 32'hE);
        if2.REQ = 4'b0000;
        @(negedge clk);
        chk("h2_oenb_c2", 32'(if2.OENB_N), 32'hE);
        chk("h2_busy_drive", 32'(if2.BUSY), 32'd1);
        @(negedge clk);
        chk("h2_valid", 32'(if2.VALID), 32'd1);
        chk("h2_src", 32'(if2.SRC), 32'd0);
        chk("h2_data", 32'(if2.DATA_OUT), 32'h5A);
        @(negedge clk);
        chk("h2_busy_idle", 32'(if2.BUSY), 32'd0);
        chk("h2_oenb_idle", 32'(if2.OENB_N), 32'hF);

        // Reset in the middle of a drive releases the bus between edges.
        if3.REQ = 4'b0001;
        @(negedge clk);
        chk("h3_pre_reset_drive", 32'(if3.OENB_N), 32'hE);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_oenb", 32'(if3.OENB_N), 32'hF);
        chk("async_rst_valid", 32'(if3.VALID), 32'd0);
        if3.REQ = 4'b1010;
        @(negedge clk);
        chk("rst_hold_valid", 32'(if3.VALID), 32'd0);
        chk("rst_hold_oenb", 32'(if3.OENB_N), 32'hF);
        chk("rst_hold_busy", 32'(if3.BUSY), 32'd0);
        prev_oe[2] = 4'b1111;
        rst = 1'b0;
        val3[1] = 8'h77;
        push(3, 3'd1, 8'h77);
        @(negedge clk);
        chk("post_rst_src1_first", 32'(if3.OENB_N), 32'hD);
        if3.REQ = 4'b0000;
        seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            @(negedge clk);
            if (if3.VALID) seen = 1;
        end
        chk("post_rst_valid_seen", 32'(seen), 32'd1);
        @(negedge clk);
        chk("post_rst_busy_idle", 32'(if3.BUSY), 32'd0);

        repeat (3) @(negedge clk);
        chk("sb_drained_h1", 32'(q1.size()), 32'd0);
        chk("sb_drained_h2", 32'(q2.size()), 32'd0);
        chk("sb_drained_h3", 32'(q3.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
